// File: rtl/control_unit.sv
// Hardwired T0..T6 sequencer for the 16-bit accumulator CPU: fetch, decode, indirect, execute, halt.
// Latency: strobes are combinational from state/SC/latched opcode and last one cycle; 4..7 cycles per instruction.
// Backpressure: none; i_start is only honoured in IDLE or HALT and is ignored while running.
module control_unit #(
    parameter int OPW = 3,
    parameter int AW  = 12
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [AW+OPW:0]       i_ir,
    input  logic                  i_ac_neg,
    input  logic                  i_ac_zero,
    input  logic                  i_dr_zero,
    input  logic                  i_e,
    output logic                  o_clr_reg,
    output logic                  o_ar_pc,
    output logic                  o_ar_ir,
    output logic                  o_ar_mem,
    output logic                  o_ld_ir,
    output logic                  o_inc_pc,
    output logic                  o_skip,
    output logic                  o_read,
    output logic                  o_write,
    output logic                  o_and,
    output logic                  o_add,
    output logic                  o_load,
    output logic                  o_store,
    output logic                  o_branch,
    output logic                  o_bsa,
    output logic                  o_isz,
    output logic                  o_clr_ac,
    output logic                  o_clr_e,
    output logic                  o_comp_ac,
    output logic                  o_comp_e,
    output logic                  o_cir_r,
    output logic                  o_cir_l,
    output logic                  o_inc_ac,
    output logic [2:0]            o_sc,
    output logic                  o_halted
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    localparam logic [OPW-1:0] OP_AND = OPW'(0);
    localparam logic [OPW-1:0] OP_ADD = OPW'(1);
    localparam logic [OPW-1:0] OP_LDA = OPW'(2);
    localparam logic [OPW-1:0] OP_STA = OPW'(3);
    localparam logic [OPW-1:0] OP_BUN = OPW'(4);
    localparam logic [OPW-1:0] OP_BSA = OPW'(5);
    localparam logic [OPW-1:0] OP_ISZ = OPW'(6);
    localparam logic [OPW-1:0] OP_REG = OPW'(7);

    state_t           state, state_nx;
    logic [2:0]       sc, sc_nx;
    logic [OPW-1:0]   op, op_nx;
    logic             ind, ind_nx;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            sc    <= 3'd0;
            op    <= '0;
            ind   <= 1'b0;
        end else begin
            state <= state_nx;
            sc    <= sc_nx;
            op    <= op_nx;
            ind   <= ind_nx;
        end
    end

    assign o_sc = sc;

    always_comb begin
        state_nx  = state;
        sc_nx     = sc;
        op_nx     = op;
        ind_nx    = ind;
        o_clr_reg = 1'b0;
        o_ar_pc   = 1'b0;
        o_ar_ir   = 1'b0;
        o_ar_mem  = 1'b0;
        o_ld_ir   = 1'b0;
        o_inc_pc  = 1'b0;
        o_skip    = 1'b0;
        o_read    = 1'b0;
        o_write   = 1'b0;
        o_and     = 1'b0;
        o_add     = 1'b0;
        o_load    = 1'b0;
        o_store   = 1'b0;
        o_branch  = 1'b0;
        o_bsa     = 1'b0;
        o_isz     = 1'b0;
        o_clr_ac  = 1'b0;
        o_clr_e   = 1'b0;
        o_comp_ac = 1'b0;
        o_comp_e  = 1'b0;
        o_cir_r   = 1'b0;
        o_cir_l   = 1'b0;
        o_inc_ac  = 1'b0;
        o_halted  = 1'b0;

        unique case (state)
            IDLE: begin
                sc_nx = 3'd0;
                if (i_start) begin
                    // Gated by reset so no strobe can leak while the core is held.
                    o_clr_reg = i_rst_n;
                    state_nx  = RUN;
                end
            end
            HALT: begin
                o_halted = 1'b1;
                sc_nx    = 3'd0;
                if (i_start) begin
                    o_clr_reg = 1'b1;
                    state_nx  = RUN;
                end
            end
            RUN: begin
                unique case (sc)
                    3'd0: begin
                        o_ar_pc = 1'b1;
                        sc_nx   = 3'd1;
                    end
                    3'd1: begin
                        o_read   = 1'b1;
                        o_ld_ir  = 1'b1;
                        o_inc_pc = 1'b1;
                        sc_nx    = 3'd2;
                    end
                    3'd2: begin
                        o_ar_ir = 1'b1;
                        op_nx   = i_ir[AW +: OPW];
                        ind_nx  = i_ir[AW+OPW];
                        sc_nx   = 3'd3;
                    end
                    3'd3: begin
                        if (op != OP_REG) begin
                            o_read   = ind;
                            o_ar_mem = ind;
                            sc_nx    = 3'd4;
                        end else begin
                            sc_nx = 3'd0;
                            // I=1 with op=111 is the I/O group, which this core treats as a no-op.
                            if (!ind) begin
                                o_clr_ac  = i_ir[11];
                                o_clr_e   = i_ir[10];
                                o_comp_ac = i_ir[9];
                                o_comp_e  = i_ir[8];
                                o_cir_r   = i_ir[7];
                                o_cir_l   = i_ir[6];
                                o_inc_ac  = i_ir[5];
                                o_skip    = (i_ir[4] & ~i_ac_neg) | (i_ir[3] & i_ac_neg) |
                                            (i_ir[2] & i_ac_zero) | (i_ir[1] & ~i_e);
                                if (i_ir[0]) state_nx = HALT;
                            end
                        end
                    end
                    3'd4: begin
                        sc_nx = 3'd0;
                        unique case (op)
                            OP_AND, OP_ADD, OP_LDA: begin
                                o_read = 1'b1;
                                sc_nx  = 3'd5;
                            end
                            OP_STA: begin
                                o_write = 1'b1;
                                o_store = 1'b1;
                            end
                            OP_BUN: o_branch = 1'b1;
                            OP_BSA: begin
                                o_write = 1'b1;
                                o_bsa   = 1'b1;
                                sc_nx   = 3'd5;
                            end
                            OP_ISZ: begin
                                o_read = 1'b1;
                                sc_nx  = 3'd5;
                            end
                            default: ;
                        endcase
                    end
                    3'd5: begin
                        sc_nx = 3'd0;
                        unique case (op)
                            OP_AND: o_and    = 1'b1;
                            OP_ADD: o_add    = 1'b1;
                            OP_LDA: o_load   = 1'b1;
                            OP_BSA: o_branch = 1'b1;
                            OP_ISZ: begin
                                o_isz = 1'b1;
                                sc_nx = 3'd6;
                            end
                            default: ;
                        endcase
                    end
                    3'd6: begin
                        sc_nx = 3'd0;
                        if (op == OP_ISZ) begin
                            o_write = 1'b1;
                            o_skip  = i_dr_zero;
                        end
                    end
                    default: sc_nx = 3'd0;
                endcase
            end
            default: begin
                state_nx = IDLE;
                sc_nx    = 3'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: hand-written vector table, random instruction stream checked against a
// per-instruction strobe-sequence model, plus halt, restart and mid-instruction reset sequences.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        i_rst_n, i_start, i_ac_neg, i_ac_zero, i_dr_zero, i_e;
    logic [15:0] i_ir;
    logic        o_clr_reg, o_ar_pc, o_ar_ir, o_ar_mem, o_ld_ir, o_inc_pc, o_skip, o_read, o_write;
    logic        o_and, o_add, o_load, o_store, o_branch, o_bsa, o_isz;
    logic        o_clr_ac, o_clr_e, o_comp_ac, o_comp_e, o_cir_r, o_cir_l, o_inc_ac, o_halted;
    logic [2:0]  o_sc;

    control_unit #(.OPW(3), .AW(12)) dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_ir(i_ir),
        .i_ac_neg(i_ac_neg), .i_ac_zero(i_ac_zero), .i_dr_zero(i_dr_zero), .i_e(i_e),
        .o_clr_reg(o_clr_reg), .o_ar_pc(o_ar_pc), .o_ar_ir(o_ar_ir), .o_ar_mem(o_ar_mem),
        .o_ld_ir(o_ld_ir), .o_inc_pc(o_inc_pc), .o_skip(o_skip), .o_read(o_read), .o_write(o_write),
        .o_and(o_and), .o_add(o_add), .o_load(o_load), .o_store(o_store), .o_branch(o_branch),
        .o_bsa(o_bsa), .o_isz(o_isz), .o_clr_ac(o_clr_ac), .o_clr_e(o_clr_e), .o_comp_ac(o_comp_ac),
        .o_comp_e(o_comp_e), .o_cir_r(o_cir_r), .o_cir_l(o_cir_l), .o_inc_ac(o_inc_ac),
        .o_sc(o_sc), .o_halted(o_halted)
    );

    always #5 clk = ~clk;

    localparam logic [23:0] S_CLR_REG = 24'd1 << 0,  S_AR_PC  = 24'd1 << 1,  S_AR_IR  = 24'd1 << 2;
    localparam logic [23:0] S_AR_MEM  = 24'd1 << 3,  S_LD_IR  = 24'd1 << 4,  S_INC_PC = 24'd1 << 5;
    localparam logic [23:0] S_SKIP    = 24'd1 << 6,  S_READ   = 24'd1 << 7,  S_WRITE  = 24'd1 << 8;
    localparam logic [23:0] S_AND     = 24'd1 << 9,  S_ADD    = 24'd1 << 10, S_LOAD   = 24'd1 << 11;
    localparam logic [23:0] S_STORE   = 24'd1 << 12, S_BRANCH = 24'd1 << 13, S_BSA    = 24'd1 << 14;
    localparam logic [23:0] S_ISZ     = 24'd1 << 15, S_CLR_AC = 24'd1 << 16, S_CLR_E  = 24'd1 << 17;
    localparam logic [23:0] S_COMP_AC = 24'd1 << 18, S_COMP_E = 24'd1 << 19, S_CIR_R  = 24'd1 << 20;
    localparam logic [23:0] S_CIR_L   = 24'd1 << 21, S_INC_AC = 24'd1 << 22, S_HALTED = 24'd1 << 23;

    logic [23:0] dut_w;
    assign dut_w = {o_halted, o_inc_ac, o_cir_l, o_cir_r, o_comp_e, o_comp_ac, o_clr_e, o_clr_ac,
                    o_isz, o_bsa, o_branch, o_store, o_load, o_add, o_and, o_write, o_read,
                    o_skip, o_inc_pc, o_ld_ir, o_ar_mem, o_ar_ir, o_ar_pc, o_clr_reg};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected strobe word for each cycle of one instruction, listed straight from the ISA description.
    logic [23:0] exp_w [7];
    int          exp_n;
    logic        exp_halt;

    task automatic build_model(input logic [15:0] ir, input logic neg, zero, dz, e);
        logic [2:0]  op;
        logic        ind;
        logic [23:0] rr;
        op  = ir[14:12];
        ind = ir[15];
        for (int i = 0; i < 7; i++) exp_w[i] = '0;
        exp_halt = 1'b0;
        exp_w[0] = S_AR_PC;
        exp_w[1] = S_READ | S_LD_IR | S_INC_PC;
        exp_w[2] = S_AR_IR;
        if (op == 3'd7) begin
            exp_n = 4;
            if (!ind) begin
                rr = '0;
                if (ir[11]) rr |= S_CLR_AC;
                if (ir[10]) rr |= S_CLR_E;
                if (ir[9])  rr |= S_COMP_AC;
                if (ir[8])  rr |= S_COMP_E;
                if (ir[7])  rr |= S_CIR_R;
                if (ir[6])  rr |= S_CIR_L;
                if (ir[5])  rr |= S_INC_AC;
                if ((ir[4] && !neg) || (ir[3] && neg) || (ir[2] && zero) || (ir[1] && !e)) rr |= S_SKIP;
                exp_w[3] = rr;
                exp_halt = ir[0];
            end
        end else begin
            exp_w[3] = ind ? (S_READ | S_AR_MEM) : 24'd0;
            case (op)
                3'd0, 3'd1, 3'd2: begin
                    exp_n = 6;
                    exp_w[4] = S_READ;
                    exp_w[5] = (op == 3'd0) ? S_AND : (op == 3'd1) ? S_ADD : S_LOAD;
                end
                3'd3: begin exp_n = 5; exp_w[4] = S_WRITE | S_STORE; end
                3'd4: begin exp_n = 5; exp_w[4] = S_BRANCH; end
                3'd5: begin exp_n = 6; exp_w[4] = S_WRITE | S_BSA; exp_w[5] = S_BRANCH; end
                default: begin
                    exp_n = 7;
                    exp_w[4] = S_READ;
                    exp_w[5] = S_ISZ;
                    exp_w[6] = S_WRITE | (dz ? S_SKIP : 24'd0);
                end
            endcase
        end
    endtask

    // Entered at T0 (just after the edge); leaves just after the edge that ends the instruction.
    task automatic run_instr(input logic [15:0] ir, input logic neg, zero, dz, e,
                             output int cyc, output logic [23:0] last);
        int k;
        build_model(ir, neg, zero, dz, e);
        k = 0;
        last = '0;
        while (k < 10) begin
            i_ir = ir; i_ac_neg = neg; i_ac_zero = zero; i_dr_zero = dz; i_e = e;
            i_start = 1'($urandom_range(0, 1));
            #1;
            if (k < exp_n) chk($sformatf("strobes ir=%h T%0d", ir, k), dut_w, exp_w[k]);
            chk($sformatf("sc ir=%h", ir), {21'd0, o_sc}, 24'(k));
            last = dut_w;
            step();
            k++;
            if (o_sc == 3'd0) break;
        end
        cyc = k;
        chk($sformatf("cycles ir=%h", ir), 24'(cyc), 24'(exp_n));
        chk($sformatf("halted after ir=%h", ir), {23'd0, o_halted}, {23'd0, exp_halt});
        i_start = 1'b0;
    endtask

    task automatic do_start(input logic [23:0] base);
        i_start = 1'b1;
        #1;
        chk("start pulse", dut_w, base | S_CLR_REG);
        chk("start sc", {21'd0, o_sc}, 24'd0);
        step();
        i_start = 1'b0;
    endtask

    typedef struct {
        logic [15:0] ir;
        logic        neg, zero, dz, e;
        int          cyc;
        logic [23:0] last;
    } vec_t;

    vec_t tbl [13];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          cyc;
        logic [23:0] last;

        tbl[0]  = '{16'h1123, 0, 0, 0, 0, 6, S_ADD};
        tbl[1]  = '{16'hE123, 0, 0, 1, 0, 7, S_WRITE | S_SKIP};
        tbl[2]  = '{16'hE123, 0, 0, 0, 0, 7, S_WRITE};
        tbl[3]  = '{16'h7A10, 0, 0, 0, 1, 4, S_CLR_AC | S_COMP_AC | S_SKIP};
        tbl[4]  = '{16'h7A10, 1, 0, 0, 1, 4, S_CLR_AC | S_COMP_AC};
        tbl[5]  = '{16'h3456, 0, 0, 0, 0, 5, S_WRITE | S_STORE};
        tbl[6]  = '{16'hC456, 0, 0, 0, 0, 5, S_BRANCH};
        tbl[7]  = '{16'h5010, 0, 0, 0, 0, 6, S_BRANCH};
        tbl[8]  = '{16'h0010, 0, 0, 0, 0, 6, S_AND};
        tbl[9]  = '{16'hA010, 0, 0, 0, 0, 6, S_LOAD};
        tbl[10] = '{16'h701E, 1, 1, 0, 0, 4, S_SKIP};
        tbl[11] = '{16'hF800, 0, 0, 0, 0, 4, 24'd0};
        tbl[12] = '{16'h7020, 0, 0, 0, 1, 4, S_INC_AC};

        i_rst_n = 1'b0; i_start = 1'b1; i_ir = 16'hFFFF;
        i_ac_neg = 1'b0; i_ac_zero = 1'b0; i_dr_zero = 1'b0; i_e = 1'b0;
        #3;
        chk("reset strobes", dut_w, 24'd0);
        chk("reset sc", {21'd0, o_sc}, 24'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        i_rst_n = 1'b1; i_start = 1'b0;
        step();
        repeat (3) begin
            #1;
            chk("idle strobes", dut_w, 24'd0);
            chk("idle sc", {21'd0, o_sc}, 24'd0);
            step();
        end
        do_start(24'd0);

        for (int v = 0; v < 13; v++) begin
            run_instr(tbl[v].ir, tbl[v].neg, tbl[v].zero, tbl[v].dz, tbl[v].e, cyc, last);
            chk($sformatf("table %0d cycles", v), 24'(cyc), 24'(tbl[v].cyc));
            chk($sformatf("table %0d last cycle", v), last, tbl[v].last);
        end

        run_instr(16'h7001, 0, 0, 0, 0, cyc, last);
        for (int c = 0; c < 20; c++) begin
            i_ir = 16'($urandom); i_ac_neg = 1'($urandom); i_dr_zero = 1'($urandom);
            #1;
            chk($sformatf("halt hold %0d", c), dut_w, S_HALTED);
            chk("halt sc", {21'd0, o_sc}, 24'd0);
            step();
        end
        do_start(S_HALTED);
        run_instr(16'h2123, 0, 0, 0, 0, cyc, last);
        chk("lda after restart", last, S_LOAD);

        for (int r = 0; r < 150; r++) begin
            run_instr(16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), cyc, last);
            if (o_halted) do_start(S_HALTED);
        end

        // Reset while BSA is in T5.
        for (int k = 0; k < 5; k++) begin
            i_ir = 16'h5010;
            i_start = 1'b0;
            step();
        end
        #1;
        chk("bsa T5", dut_w, S_BRANCH);
        chk("bsa T5 sc", {21'd0, o_sc}, 24'd5);
        i_start = 1'b1;
        #1;
        i_rst_n = 1'b0;
        #1;
        chk("mid reset strobes", dut_w, 24'd0);
        chk("mid reset sc", {21'd0, o_sc}, 24'd0);
        @(negedge clk);
        i_rst_n = 1'b1; i_start = 1'b0;
        step();
        repeat (4) begin
            #1;
            chk("post reset idle", dut_w, 24'd0);
            chk("post reset sc", {21'd0, o_sc}, 24'd0);
            step();
        end
        do_start(24'd0);
        run_instr(16'h4321, 0, 0, 0, 0, cyc, last);
        chk("bun after reset", last, S_BRANCH);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
